mjpg_stream_parser: RTL and testbench

MJPG_STREAM_PARSER -- requirements
Module: mjpg_stream_parser

---
 rtl/mjpg_pkg.sv | 35 +++
 rtl/mjpg_byte_skid.sv | 44 ++++
 rtl/mjpg_stream_parser.sv | 230 +++++++++++++++++++++++
 tb/tb_mjpg_stream_parser.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mjpg_pkg.sv
// Shared marker codes and parser state encoding for the MJPEG stream parser.
package mjpg_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_HUNT_FF,
    ST_MARKER,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_SEG_BODY,
    ST_ECS,
    ST_ECS_FF
  } state_t;

  localparam logic [7:0] M_FF    = 8'hFF;
  localparam logic [7:0] M_STUFF = 8'h00;
  localparam logic [7:0] M_SOI   = 8'hD8;
  localparam logic [7:0] M_EOI   = 8'hD9;
  localparam logic [7:0] M_SOS   = 8'hDA;
  localparam logic [7:0] M_SOF0  = 8'hC0;
  localparam logic [7:0] M_RST0  = 8'hD0;

  // RST0..RST7 share the upper five bits of D0.
  function automatic logic is_rst_marker(input logic [7:0] code);
    return code[7:3] == M_RST0[7:3];
  endfunction

  // Marker codes that carry a length-prefixed segment.
  function automatic logic is_seg_marker(input logic [7:0] code);
    return (code[7:4] == 4'hC) || (code[7:4] == 4'hE) ||
           (code == 8'hDB) || (code == 8'hDD) || (code == 8'hFE) ||
           (code == M_SOS);
  endfunction

endpackage

// File: rtl/mjpg_byte_skid.sv
// One-entry output register: holds data stable under backpressure, reloads on transfer.
module mjpg_byte_skid
  import mjpg_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              can_accept,
  output logic              ovalid,
  input  logic              oready,
  output logic [DATA_W-1:0] odata,
  output logic              olast
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              last_p1;

  assign can_accept = !vld_p1 || oready;
  assign ovalid     = vld_p1;
  assign odata      = data_p1;
  assign olast      = last_p1;

  // p1: output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (in_vld && can_accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data;
      last_p1 <= in_last;
    end else if (vld_p1 && oready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

endmodule

// File: rtl/mjpg_stream_parser.sv
// MJPEG byte-stream parser: walks JPEG markers, captures SOF0 size, emits unstuffed ECS bytes.
module mjpg_stream_parser
  import mjpg_pkg::*;
#(
  parameter int STRICT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [7:0]  jpeg,
  output logic        dequeue,
  output logic        ovalid,
  input  logic        oready,
  output logic [7:0]  odata,
  output logic        olast,
  output logic [15:0] width,
  output logic [15:0] height,
  output logic        frame_start,
  output logic        frame_done,
  output logic        err
);

  state_t      state, state_n;
  logic        mk_ff, mk_ff_n;
  logic        is_sos, sos_n;
  logic        is_sof0, sof0_n;
  logic [7:0]  len_hi, len_hi_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  off, off_n;
  logic        vld_p0, vld_p0_n;
  logic [7:0]  data_p0, data_p0_n;
  logic [15:0] width_n, height_n;
  logic        start_n, done_n, err_n;
  logic        fwd_vld, fwd_last;
  logic        can_accept;
  logic        in_ecs;
  logic [15:0] seg_len;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [15:0] sat_dec16(input logic [15:0] v);
    return (v == 16'd0) ? v : v - 16'd1;
  endfunction

  assign in_ecs  = (state == ST_ECS) || (state == ST_ECS_FF);
  assign dequeue = rst && ready && (!in_ecs || can_accept);
  assign seg_len = {len_hi, jpeg};

  always_comb begin
    state_n   = state;
    mk_ff_n   = mk_ff;
    sos_n     = is_sos;
    sof0_n    = is_sof0;
    len_hi_n  = len_hi;
    cnt_n     = cnt;
    off_n     = off;
    vld_p0_n  = vld_p0;
    data_p0_n = data_p0;
    width_n   = width;
    height_n  = height;
    start_n   = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    fwd_vld   = 1'b0;
    fwd_last  = 1'b0;
    if (dequeue) begin
      case (state)
        ST_HUNT: begin
          if (jpeg == M_FF) state_n = ST_HUNT_FF;
        end
        ST_HUNT_FF: begin
          if (jpeg == M_SOI) begin
            start_n  = 1'b1;
            mk_ff_n  = 1'b0;
            vld_p0_n = 1'b0;
            state_n  = ST_MARKER;
          end else if (jpeg != M_FF) begin
            state_n = ST_HUNT;
          end
        end
        ST_MARKER: begin
          if (jpeg == M_FF) begin
            mk_ff_n = 1'b1;
          end else if (!mk_ff) begin
            err_n   = 1'b1;
            state_n = ST_HUNT;
          end else begin
            mk_ff_n = 1'b0;
            if (jpeg == M_SOI) begin
              // a fresh SOI restarts the frame in place
              err_n   = 1'b1;
              start_n = 1'b1;
            end else if (jpeg == M_EOI) begin
              done_n  = 1'b1;
              state_n = ST_HUNT;
            end else if (is_seg_marker(jpeg)) begin
              sos_n   = (jpeg == M_SOS);
              sof0_n  = (jpeg == M_SOF0);
              state_n = ST_LEN_HI;
            end else begin
              err_n   = 1'b1;
              state_n = ST_HUNT;
            end
          end
        end
        ST_LEN_HI: begin
          len_hi_n = jpeg;
          state_n  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          off_n = 3'd0;
          if (seg_len < 16'd2) begin
            cnt_n   = 16'd0;
            err_n   = 1'b1;
            state_n = ST_HUNT;
          end else begin
            cnt_n = seg_len - 16'd2;
            if (seg_len == 16'd2) state_n = is_sos ? ST_ECS : ST_MARKER;
            else                  state_n = ST_SEG_BODY;
          end
        end
        ST_SEG_BODY: begin
          if (is_sof0) begin
            case (off)
              3'd1:    height_n[15:8] = jpeg;
              3'd2:    height_n[7:0]  = jpeg;
              3'd3:    width_n[15:8]  = jpeg;
              3'd4:    width_n[7:0]   = jpeg;
              default: ;
            endcase
          end
          off_n = sat_inc3(off);
          cnt_n = sat_dec16(cnt);
          if (cnt <= 16'd1) state_n = is_sos ? ST_ECS : ST_MARKER;
        end
        ST_ECS: begin
          if (jpeg == M_FF) begin
            state_n = ST_ECS_FF;
          end else begin
            fwd_vld   = vld_p0;
            vld_p0_n  = 1'b1;
            data_p0_n = jpeg;
          end
        end
        ST_ECS_FF: begin
          if (jpeg == M_STUFF) begin
            fwd_vld   = vld_p0;
            vld_p0_n  = 1'b1;
            data_p0_n = M_FF;
            state_n   = ST_ECS;
          end else if (jpeg == M_FF) begin
            state_n = ST_ECS_FF;
          end else if (is_rst_marker(jpeg)) begin
            state_n = ST_ECS;
          end else if (jpeg == M_EOI) begin
            // the held byte is the last of the frame
            fwd_vld  = vld_p0;
            fwd_last = 1'b1;
            vld_p0_n = 1'b0;
            done_n   = 1'b1;
            state_n  = ST_HUNT;
          end else if (jpeg == M_SOI) begin
            err_n    = 1'b1;
            start_n  = 1'b1;
            vld_p0_n = 1'b0;
            mk_ff_n  = 1'b0;
            state_n  = ST_MARKER;
          end else if (STRICT != 0) begin
            err_n    = 1'b1;
            vld_p0_n = 1'b0;
            state_n  = ST_HUNT;
          end else begin
            state_n = ST_ECS;
          end
        end
        default: state_n = ST_HUNT;
      endcase
    end
  end

  // p0: control state, pending-byte valid, captured size, event pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_HUNT;
      mk_ff       <= 1'b0;
      is_sos      <= 1'b0;
      is_sof0     <= 1'b0;
      vld_p0      <= 1'b0;
      width       <= 16'd0;
      height      <= 16'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      mk_ff       <= mk_ff_n;
      is_sos      <= sos_n;
      is_sof0     <= sof0_n;
      vld_p0      <= vld_p0_n;
      width       <= width_n;
      height      <= height_n;
      frame_start <= start_n;
      frame_done  <= done_n;
      err         <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    len_hi  <= len_hi_n;
    cnt     <= cnt_n;
    off     <= off_n;
    data_p0 <= data_p0_n;
  end

  mjpg_byte_skid #(.DATA_W(8)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (fwd_vld),
    .in_data    (data_p0),
    .in_last    (fwd_last),
    .can_accept (can_accept),
    .ovalid     (ovalid),
    .oready     (oready),
    .odata      (odata),
    .olast      (olast)
  );

endmodule

// File: tb/tb_mjpg_stream_parser.sv
// Randomized self-checking bench for mjpg_stream_parser; expectations come from frame construction.
module tb_mjpg_stream_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        src_ready = 1'b0;
  logic [7:0]  jpeg = 8'h00;
  logic        oready = 1'b1;
  logic        sel = 1'b0;
  logic        ready_a, ready_b;

  logic        dq_a, ov_a, ol_a, fs_a, fd_a, er_a;
  logic [7:0]  od_a;
  logic [15:0] w_a, h_a;
  logic        dq_b, ov_b, ol_b, fs_b, fd_b, er_b;
  logic [7:0]  od_b;
  logic [15:0] w_b, h_b;

  logic        dq, ov, ol, fs, fd, er;
  logic [7:0]  od;
  logic [15:0] w_o, h_o;

  assign ready_a = src_ready && !sel;
  assign ready_b = src_ready && sel;
  assign dq  = sel ? dq_b : dq_a;
  assign ov  = sel ? ov_b : ov_a;
  assign ol  = sel ? ol_b : ol_a;
  assign od  = sel ? od_b : od_a;
  assign fs  = sel ? fs_b : fs_a;
  assign fd  = sel ? fd_b : fd_a;
  assign er  = sel ? er_b : er_a;
  assign w_o = sel ? w_b : w_a;
  assign h_o = sel ? h_b : h_a;

  mjpg_stream_parser #(.STRICT(1)) dut_s (
    .clk(clk), .rst(rst), .ready(ready_a), .jpeg(jpeg), .dequeue(dq_a),
    .ovalid(ov_a), .oready(oready), .odata(od_a), .olast(ol_a),
    .width(w_a), .height(h_a), .frame_start(fs_a), .frame_done(fd_a), .err(er_a)
  );

  mjpg_stream_parser #(.STRICT(0)) dut_l (
    .clk(clk), .rst(rst), .ready(ready_b), .jpeg(jpeg), .dequeue(dq_b),
    .ovalid(ov_b), .oready(oready), .odata(od_b), .olast(ol_b),
    .width(w_b), .height(h_b), .frame_start(fs_b), .frame_done(fd_b), .err(er_b)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_d[$];
  logic       exp_l[$];
  logic [7:0] got_d[$];
  logic       got_l[$];
  int  fs_cnt, fd_cnt, err_cnt;
  int  cyc = 0, d8_cyc = -1, fs_cyc = -1;
  bit  pop_pending = 0;
  bit  gaps_en = 0;
  int  oready_mode = 0;

  // Source FIFO and sink, both updated just after the active edge.
  always @(posedge clk) begin
    #1;
    if (pop_pending && src_q.size() > 0) void'(src_q.pop_front());
    pop_pending = 0;
    src_ready = (src_q.size() > 0) && !(gaps_en && $urandom_range(0, 3) == 0);
    jpeg = (src_q.size() > 0) ? src_q[0] : 8'h00;
    oready = (oready_mode == 0) ? 1'b1 : (oready_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  always @(negedge clk) begin
    cyc++;
    pop_pending = dq;
    if (rst) begin
      if (dq && jpeg == 8'hD8) d8_cyc = cyc;
      if (ov && oready) begin
        got_d.push_back(od);
        got_l.push_back(ol);
      end
      if (fs) begin fs_cnt++; fs_cyc = cyc; end
      if (fd) fd_cnt++;
      if (er) err_cnt++;
    end
  end

  task automatic put(input logic [7:0] b);
    src_q.push_back(b);
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic last);
    exp_d.push_back(b);
    exp_l.push_back(last);
  endtask

  task automatic clear_obs();
    exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
    fs_cnt = 0; fd_cnt = 0; err_cnt = 0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int idle = 0;
    int k = 0;
    while (idle < 4 && k < max_cyc) begin
      @(negedge clk);
      k++;
      if (src_q.size() == 0 && !ov) idle++;
      else idle = 0;
    end
    checks++;
    if (idle < 4) begin
      errors++;
      $display("FAIL %s_timeout got queue=%0d ovalid=%b required idle within %0d cycles", name, src_q.size(), ov, max_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dq_a, ov_a, ol_a, fs_a, fd_a, er_a, dq_b, ov_b, ol_b, fs_b, fd_b, er_b} !== 12'd0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=0", {dq_a, ov_a, ol_a, fs_a, fd_a, er_a, dq_b, ov_b, ol_b, fs_b, fd_b, er_b});
    end
    checks++;
    if ({od_a, w_a, h_a, od_b, w_b, h_b} !== 80'd0) begin
      errors++;
      $display("FAIL reset_data got=%h required=0", {od_a, w_a, h_a, od_b, w_b, h_b});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [7:0] hdr[$] = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, 8'h00, 8'hF0, 8'h01, 8'h40};
    logic [7:0] ecs[$] = '{8'h12, 8'h34, 8'hFF, 8'h00, 8'h56, 8'hFF, 8'hD9};
    clear_obs();
    foreach (hdr[i]) put(hdr[i]);
    repeat (10) put(8'h00);
    put(8'hFF); put(8'hDA); put(8'h00); put(8'h08);
    repeat (6) put(8'h00);
    foreach (ecs[i]) put(ecs[i]);
    expect_byte(8'h12, 0); expect_byte(8'h34, 0); expect_byte(8'hFF, 0); expect_byte(8'h56, 1);
    wait_idle("basic", 400);
    checks++;
    if (h_o !== 16'd240) begin errors++; $display("FAIL basic_height got=%0d required=240", h_o); end
    checks++;
    if (w_o !== 16'd320) begin errors++; $display("FAIL basic_width got=%0d required=320", w_o); end
    checks++;
    if ({fs_cnt, fd_cnt, err_cnt} !== {32'd1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL basic_events got fs=%0d fd=%0d err=%0d required 1/1/0", fs_cnt, fd_cnt, err_cnt);
    end
    checks++;
    if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL basic_count got=%0d required=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
        errors++; $display("FAIL basic_byte%0d got=%h/%b required=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_restart_marker();
    logic [7:0] s[$] = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h02, 8'h01, 8'hFF, 8'hD3, 8'h02, 8'hFF, 8'hD9};
    clear_obs();
    foreach (s[i]) put(s[i]);
    expect_byte(8'h01, 0); expect_byte(8'h02, 1);
    wait_idle("rstm", 200);
    checks++;
    if ({fd_cnt, err_cnt} !== {32'd1, 32'd0}) begin errors++; $display("FAIL rstm_events got fd=%0d err=%0d required 1/0", fd_cnt, err_cnt); end
    checks++;
    if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL rstm_count got=%0d required=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
        errors++; $display("FAIL rstm_byte%0d got=%h/%b required=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_empty_eoi();
    logic [7:0] s[$] = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h02, 8'hFF, 8'hD9};
    clear_obs();
    foreach (s[i]) put(s[i]);
    wait_idle("empty", 200);
    checks++;
    if ({fd_cnt, err_cnt, got_d.size()} !== {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL empty_eoi got fd=%0d err=%0d bytes=%0d required 1/0/0", fd_cnt, err_cnt, got_d.size());
    end
    checks++;
    if (w_o !== 16'd320) begin errors++; $display("FAIL empty_width_kept got=%0d required=320", w_o); end
  endtask

  task automatic test_backpressure();
    int n_dq = 0, bad = 0, k = 0;
    bit have = 0;
    logic [7:0] hold = 8'h00;
    int got_before;
    clear_obs();
    put(8'hFF); put(8'hD8); put(8'hFF); put(8'hDA); put(8'h00); put(8'h02);
    for (int i = 0; i < 3; i++) begin put(8'h10 + 8'(i)); expect_byte(8'h10 + 8'(i), 0); end
    while (src_q.size() != 0 && k < 100) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    oready_mode = 2;
    @(posedge clk); #2;
    got_before = got_d.size();
    for (int i = 3; i < 11; i++) begin put(8'h10 + 8'(i)); expect_byte(8'h10 + 8'(i), i == 10); end
    put(8'hFF); put(8'hD9);
    repeat (20) begin
      @(negedge clk);
      if (dq) n_dq++;
      if (ov) begin
        if (!have) begin have = 1; hold = od; end
        else if (od !== hold) bad++;
      end
    end
    checks++;
    if (n_dq > 2) begin errors++; $display("FAIL bp_dequeue_stall got=%0d dequeues required<=2", n_dq); end
    checks++;
    if (!(have && bad == 0 && ov)) begin errors++; $display("FAIL bp_hold got valid=%b changes=%0d required held byte", ov, bad); end
    checks++;
    if (got_d.size() !== got_before) begin errors++; $display("FAIL bp_no_xfer got=%0d required=%0d", got_d.size(), got_before); end
    oready_mode = 0;
    wait_idle("bp", 300);
    checks++;
    if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL bp_count got=%0d required=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
        errors++; $display("FAIL bp_byte%0d got=%h/%b required=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_strict();
    logic [7:0] s1[$] = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h02, 8'h05, 8'hFF, 8'hC4};
    logic [7:0] s2[$] = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h02, 8'h07, 8'hFF, 8'hD9};
    clear_obs();
    foreach (s1[i]) put(s1[i]);
    wait_idle("strict1", 200);
    checks++;
    if ({err_cnt, fd_cnt, got_d.size()} !== {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL strict_err got err=%0d fd=%0d bytes=%0d required 1/0/0", err_cnt, fd_cnt, got_d.size());
    end
    foreach (s2[i]) put(s2[i]);
    wait_idle("strict2", 200);
    checks++;
    if (!(got_d.size() == 1 && got_d[0] === 8'h07 && got_l[0] === 1'b1 && fd_cnt == 1)) begin
      errors++; $display("FAIL strict_recover got bytes=%0d fd=%0d required 07/last fd=1", got_d.size(), fd_cnt);
    end
    @(negedge clk);
    sel = 1'b1;
    clear_obs();
    foreach (s1[i]) put(s1[i]);
    put(8'h07); put(8'hFF); put(8'hD9);
    expect_byte(8'h05, 0); expect_byte(8'h07, 1);
    wait_idle("lenient", 200);
    checks++;
    if ({err_cnt, fd_cnt} !== {32'd0, 32'd1}) begin errors++; $display("FAIL lenient_events got err=%0d fd=%0d required 0/1", err_cnt, fd_cnt); end
    checks++;
    if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL lenient_count got=%0d required=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
        errors++; $display("FAIL lenient_byte%0d got=%h/%b required=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_soi_in_ecs();
    logic [7:0] s[$] = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h02, 8'h11, 8'h22, 8'hFF, 8'hD8,
                         8'hFF, 8'hDA, 8'h00, 8'h02, 8'h33, 8'hFF, 8'hD9};
    clear_obs();
    foreach (s[i]) put(s[i]);
    expect_byte(8'h11, 0); expect_byte(8'h33, 1);
    wait_idle("soi", 200);
    checks++;
    if ({err_cnt, fs_cnt, fd_cnt} !== {32'd1, 32'd2, 32'd1}) begin
      errors++; $display("FAIL soi_events got err=%0d fs=%0d fd=%0d required 1/2/1", err_cnt, fs_cnt, fd_cnt);
    end
    checks++;
    if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL soi_count got=%0d required=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
        errors++; $display("FAIL soi_byte%0d got=%h/%b required=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_bad_segments();
    logic [7:0] s[$] = '{8'hFF, 8'hD8, 8'hFF, 8'hE0, 8'h00, 8'h01,
                         8'hFF, 8'hD8, 8'hFF, 8'h01,
                         8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00, 8'h00};
    clear_obs();
    foreach (s[i]) put(s[i]);
    wait_idle("badseg", 200);
    checks++;
    if ({err_cnt, fs_cnt, fd_cnt} !== {32'd3, 32'd3, 32'd0}) begin
      errors++; $display("FAIL badseg_events got err=%0d fs=%0d fd=%0d required 3/3/0", err_cnt, fs_cnt, fd_cnt);
    end
  endtask

  task automatic test_garbage_sync();
    logic [7:0] s[$] = '{8'hAA, 8'hFF, 8'h55, 8'hFF, 8'hFF, 8'hD8, 8'hFF, 8'hD9};
    clear_obs();
    d8_cyc = -1; fs_cyc = -2;
    foreach (s[i]) put(s[i]);
    wait_idle("garbage", 200);
    checks++;
    if ({fs_cnt, fd_cnt, err_cnt} !== {32'd1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL garbage_events got fs=%0d fd=%0d err=%0d required 1/1/0", fs_cnt, fd_cnt, err_cnt);
    end
    checks++;
    if (fs_cyc !== d8_cyc + 1) begin errors++; $display("FAIL garbage_align got fs_cycle=%0d required=%0d", fs_cyc, d8_cyc + 1); end
  endtask

  task automatic gen_frame(input logic [15:0] w, input logic [15:0] h, input int nd);
    int n;
    logic [7:0] b;
    put(8'hFF); put(8'hD8);
    n = $urandom_range(0, 5);
    if ($urandom_range(0, 1) == 1) put(8'hFF);
    put(8'hFF); put(8'hE0 | 8'($urandom_range(0, 15))); put(8'h00); put(8'(n + 2));
    repeat (n) put(8'($urandom));
    put(8'hFF); put(8'hC0); put(8'h00); put(8'h0B); put(8'h08);
    put(h[15:8]); put(h[7:0]); put(w[15:8]); put(w[7:0]);
    put(8'h01); put(8'h01); put(8'h11); put(8'h00);
    put(8'hFF); put(8'hDA); put(8'h00); put(8'h08);
    repeat (6) put(8'($urandom));
    for (int i = 0; i < nd; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      put(b);
      if (b == 8'hFF) put(8'h00);
      expect_byte(b, i == nd - 1);
      if ($urandom_range(0, 4) == 0) begin put(8'hFF); put(8'hD0 | 8'(i % 8)); end
    end
    put(8'hFF); put(8'hD9);
  endtask

  task automatic test_random_frames();
    logic [15:0] w, h;
    gaps_en = 1; oready_mode = 1;
    for (int f = 0; f < 8; f++) begin
      clear_obs();
      w = 16'($urandom_range(1, 65535));
      h = 16'($urandom_range(1, 65535));
      gen_frame(w, h, $urandom_range(1, 24));
      wait_idle("rand", 3000);
      checks++;
      if ({w_o, h_o} !== {w, h}) begin errors++; $display("FAIL rand%0d_size got=%0dx%0d required=%0dx%0d", f, w_o, h_o, w, h); end
      checks++;
      if ({fs_cnt, fd_cnt, err_cnt} !== {32'd1, 32'd1, 32'd0}) begin
        errors++; $display("FAIL rand%0d_events got fs=%0d fd=%0d err=%0d required 1/1/0", f, fs_cnt, fd_cnt, err_cnt);
      end
      checks++;
      if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL rand%0d_count got=%0d required=%0d", f, got_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        checks++;
        if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
          errors++; $display("FAIL rand%0d_byte%0d got=%h/%b required=%h/%b", f, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
        end
      end
    end
    gaps_en = 0; oready_mode = 0;
  endtask

  task automatic test_reset_mid_segment();
    int k = 0;
    clear_obs();
    put(8'hFF); put(8'hD8); put(8'hFF); put(8'hE0); put(8'h00); put(8'h20);
    repeat (30) put(8'h5A);
    while (src_q.size() > 20 && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    rst = 1'b0;
    src_q.delete();
    @(posedge clk); #1;
    checks++;
    if ({dq_a, ov_a, ol_a, fs_a, fd_a, er_a, od_a, w_a, h_a} !== 46'd0) begin
      errors++; $display("FAIL midreset_outputs got=%h required=0", {dq_a, ov_a, ol_a, fs_a, fd_a, er_a, od_a, w_a, h_a});
    end
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (err_cnt !== 0) begin errors++; $display("FAIL midreset_err got=%0d required=0", err_cnt); end
    clear_obs();
    gen_frame(16'd64, 16'd48, 5);
    wait_idle("midreset", 400);
    checks++;
    if ({w_o, h_o, fs_cnt, fd_cnt, err_cnt} !== {16'd64, 16'd48, 32'd1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL midreset_frame got %0dx%0d fs=%0d fd=%0d err=%0d required 64x48 1/1/0", w_o, h_o, fs_cnt, fd_cnt, err_cnt);
    end
    checks++;
    if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL midreset_count got=%0d required=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
        errors++; $display("FAIL midreset_byte%0d got=%h/%b required=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_restart_marker();
    test_empty_eoi();
    test_backpressure();
    test_strict();
    test_soi_in_ecs();
    test_bad_segments();
    test_garbage_sync();
    test_random_frames();
    test_reset_mid_segment();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
